// File: rtl/lfsr_crc_arbiter.sv
// Round-robin arbiter sharing one parallel LFSR/CRC datapath among PORTS stream sources.
// Each grant covers a whole frame; the final CRC and source port go out on a valid/ready result.

module lfsr #(
  parameter int                    LFSR_WIDTH  = 32,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = 32'h04c11db7,
  parameter                        LFSR_CONFIG = "GALOIS",
  parameter bit                    REVERSE     = 1'b1,
  parameter int                    DATA_WIDTH  = 8,
  parameter                        STYLE       = "AUTO"
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic [LFSR_WIDTH-1:0] state_out
);

  function automatic logic [LFSR_WIDTH-1:0] bit_rev(input logic [LFSR_WIDTH-1:0] v);
    logic [LFSR_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < LFSR_WIDTH; i++) r[i] = v[LFSR_WIDTH-1-i];
    return r;
  endfunction

  // A reflected register is the MSB-first shifter viewed through a bit reversal,
  // so REVERSE only mirrors the state and feeds data LSB first.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] s,
                                                       input logic [DATA_WIDTH-1:0] d);
    logic [LFSR_WIDTH-1:0] st;
    logic                  db;
    logic                  fb;
    st = REVERSE ? bit_rev(s) : s;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      db = REVERSE ? d[i] : d[DATA_WIDTH-1-i];
      if (LFSR_CONFIG == "GALOIS") begin
        fb = st[LFSR_WIDTH-1] ^ db;
        st = {st[LFSR_WIDTH-2:0], 1'b0};
        if (fb) st = st ^ LFSR_POLY;
      end else begin
        fb = db ^ (^(st & {1'b1, LFSR_POLY[LFSR_WIDTH-1:1]}));
        st = {st[LFSR_WIDTH-2:0], fb};
      end
    end
    return REVERSE ? bit_rev(st) : st;
  endfunction

  // Both styles unroll to the same XOR network; LOOP keeps it inside a process.
  generate
    if (STYLE == "LOOP") begin : g_loop
      always_comb state_out = lfsr_step(state_in, data_in);
    end else begin : g_flat
      assign state_out = lfsr_step(state_in, data_in);
    end
  endgenerate

endmodule

module lfsr_crc_arbiter #(
  parameter int                    PORTS       = 4,
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    LFSR_WIDTH  = 32,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = 32'h04c11db7,
  parameter logic [LFSR_WIDTH-1:0] LFSR_INIT   = {LFSR_WIDTH{1'b1}},
  parameter                        LFSR_CONFIG = "GALOIS",
  parameter bit                    REVERSE     = 1'b1,
  parameter bit                    INVERT      = 1'b1,
  parameter                        STYLE       = "AUTO"
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PORTS*DATA_WIDTH-1:0] s_data,
  input  logic [PORTS-1:0]            s_valid,
  input  logic [PORTS-1:0]            s_last,
  output logic [PORTS-1:0]            s_ready,
  output logic [LFSR_WIDTH-1:0]       m_crc,
  output logic [$clog2(PORTS)-1:0]    m_port,
  output logic                        m_valid,
  input  logic                        m_ready
);

  localparam int PW = $clog2(PORTS);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state;
  state_t                state_next;
  logic [PW-1:0]         grant;
  logic [PW-1:0]         last_grant;
  logic [PW-1:0]         pick;
  logic [PW-1:0]         cand;
  logic [LFSR_WIDTH-1:0] state_reg;
  logic [LFSR_WIDTH-1:0] lfsr_next;
  logic [DATA_WIDTH-1:0] beat_data;
  logic                  beat;

  assign beat_data = s_data[grant*DATA_WIDTH +: DATA_WIDTH];
  assign beat      = (state == BUSY) && s_valid[grant];

  lfsr #(
    .LFSR_WIDTH (LFSR_WIDTH),
    .LFSR_POLY  (LFSR_POLY),
    .LFSR_CONFIG(LFSR_CONFIG),
    .REVERSE    (REVERSE),
    .DATA_WIDTH (DATA_WIDTH),
    .STYLE      (STYLE)
  ) lfsr_inst (
    .data_in  (beat_data),
    .state_in (state_reg),
    .state_out(lfsr_next)
  );

  // First requester strictly after the previous grant, wrapping around.
  always_comb begin
    pick = last_grant;
    cand = '0;
    for (int k = PORTS; k >= 1; k--) begin
      cand = PW'((int'(last_grant) + k) % PORTS);
      if (s_valid[cand]) pick = cand;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    s_ready    = '0;
    m_valid    = 1'b0;
    case (state)
      IDLE: if (|s_valid) state_next = BUSY;
      BUSY: begin
        s_ready[grant] = 1'b1;
        if (s_valid[grant] && s_last[grant]) state_next = DONE;
      end
      DONE: begin
        m_valid = 1'b1;
        if (m_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant      <= '0;
      last_grant <= PW'(PORTS-1);
      state_reg  <= LFSR_INIT;
      m_crc      <= '0;
      m_port     <= '0;
    end else if (state == IDLE) begin
      if (|s_valid) begin
        grant      <= pick;
        last_grant <= pick;
        state_reg  <= LFSR_INIT;
      end
    end else if (beat) begin
      state_reg <= lfsr_next;
      if (s_last[grant]) begin
        m_crc  <= INVERT ? ~lfsr_next : lfsr_next;
        m_port <= grant;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_crc_arbiter.sv
// Directed bench for lfsr_crc_arbiter: drivers push expected {port, crc} when a last beat
// is accepted; a monitor pops and compares on each result handshake.

module tb_lfsr_crc_arbiter;

  localparam int PORTS = 4;
  localparam int DW    = 8;
  localparam int LW    = 32;

  typedef logic [7:0] byte_q_t[$];

  logic              clk = 1'b0;
  logic              rst_n;
  logic [PORTS*DW-1:0] s_data;
  logic [PORTS-1:0]  s_valid;
  logic [PORTS-1:0]  s_last;
  logic [PORTS-1:0]  s_ready;
  logic [LW-1:0]     m_crc;
  logic [1:0]        m_port;
  logic              m_valid;
  logic              m_ready;

  int checks = 0;
  int fails  = 0;

  logic [33:0] sb[$];
  logic [1:0]  seen_ports[$];

  lfsr_crc_arbiter dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_data (s_data),
    .s_valid(s_valid),
    .s_last (s_last),
    .s_ready(s_ready),
    .m_crc  (m_crc),
    .m_port (m_port),
    .m_valid(m_valid),
    .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 500000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc32_ref(input byte_q_t f);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (f[i]) begin
      c = c ^ {24'h0, f[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  always @(negedge clk) begin
    logic [33:0] e;
    if (rst_n === 1'b1) begin
      check("s_ready onehot0", 64'($onehot0(s_ready)), 64'd1);
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          check("unexpected result", 64'(m_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          check("m_crc", 64'(m_crc), 64'(e[31:0]));
          check("m_port", 64'(m_port), 64'(e[33:32]));
          seen_ports.push_back(m_port);
        end
      end
    end
  end

  task automatic drive_frame(input int p, input byte_q_t f, input bit term,
                             input logic [31:0] exp_crc, input int gap_at, input int gap_len);
    int budget;
    for (int i = 0; i < f.size(); i++) begin
      @(negedge clk);
      s_valid[p]          = 1'b1;
      s_data[p*DW +: DW]  = f[i];
      s_last[p]           = term && (i == f.size() - 1);
      budget = 0;
      while (!s_ready[p] && budget < 200) begin
        @(negedge clk);
        budget++;
      end
      if (!s_ready[p]) begin
        check("grant timeout", 64'(s_ready[p]), 64'd1);
        break;
      end
      if (s_last[p]) sb.push_back({2'(p), exp_crc});
      @(posedge clk);
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clk);
          s_valid[p] = 1'b0;
          check("grant held in stall", 64'(s_ready), 64'(4'(1) << p));
        end
      end
    end
  endtask

  task automatic release_port(input int p);
    @(negedge clk);
    s_valid[p] = 1'b0;
    s_last[p]  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    s_valid = '0;
    s_last  = '0;
    s_data  = '0;
    m_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_order(input string tag, input logic [1:0] exp_q[$]);
    check({tag, " count"}, 64'(seen_ports.size()), 64'(exp_q.size()));
    foreach (exp_q[i])
      if (i < seen_ports.size()) check(tag, 64'(seen_ports[i]), 64'(exp_q[i]));
  endtask

  initial begin
    byte_q_t f9, f1234, f_a, f_b, f_c, f_d, f_e, f_f;
    logic [1:0] exp_rr[$];
    f9    = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    f1234 = '{8'h31, 8'h32, 8'h33, 8'h34};
    f_a   = '{8'h10, 8'h11};
    f_b   = '{8'h20, 8'h21};
    f_c   = '{8'h30, 8'hC3};
    f_d   = '{8'hF0, 8'h0F};
    f_e   = '{8'hA5, 8'h5A};
    f_f   = '{8'h00, 8'hFF};

    // Reset values
    rst_n = 1'b0; s_valid = '0; s_last = '0; s_data = '0; m_ready = 1'b1;
    @(negedge clk);
    check("reset s_ready", 64'(s_ready), 64'd0);
    check("reset m_valid", 64'(m_valid), 64'd0);
    check("reset m_crc", 64'(m_crc), 64'd0);
    check("reset m_port", 64'(m_port), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Check value from port 0, then one result cycle only
    drive_frame(0, f9, 1'b1, 32'hCBF43926, -1, 0);
    release_port(0);
    drain();
    @(negedge clk);
    check("m_valid one cycle", 64'(m_valid), 64'd0);

    // Single-beat frame on port 2
    drive_frame(2, '{8'h00}, 1'b1, 32'hD202EF8D, -1, 0);
    release_port(2);
    drain();

    // Round robin with all four ports requesting
    do_reset();
    seen_ports.delete();
    fork
      begin
        drive_frame(0, f_a, 1'b1, crc32_ref(f_a), -1, 0);
        drive_frame(0, f_e, 1'b1, crc32_ref(f_e), -1, 0);
        release_port(0);
      end
      begin
        drive_frame(1, f_b, 1'b1, crc32_ref(f_b), -1, 0);
        drive_frame(1, f_f, 1'b1, crc32_ref(f_f), -1, 0);
        release_port(1);
      end
      begin
        drive_frame(2, f_c, 1'b1, crc32_ref(f_c), -1, 0);
        release_port(2);
      end
      begin
        drive_frame(3, f_d, 1'b1, crc32_ref(f_d), -1, 0);
        release_port(3);
      end
    join
    drain();
    exp_rr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    check_order("rr order all", exp_rr);

    // Round robin with ports 1 and 3 only
    do_reset();
    seen_ports.delete();
    fork
      begin
        drive_frame(1, f_a, 1'b1, crc32_ref(f_a), -1, 0);
        drive_frame(1, f_b, 1'b1, crc32_ref(f_b), -1, 0);
        release_port(1);
      end
      begin
        drive_frame(3, f_d, 1'b1, crc32_ref(f_d), -1, 0);
        release_port(3);
      end
    join
    drain();
    exp_rr = '{2'd1, 2'd3, 2'd1};
    check_order("rr order 1,3", exp_rr);

    // Result backpressure with port 1 waiting
    m_ready = 1'b0;
    drive_frame(0, '{8'hA5}, 1'b1, crc32_ref('{8'hA5}), -1, 0);
    release_port(0);
    fork
      begin
        drive_frame(1, '{8'h5A}, 1'b1, crc32_ref('{8'h5A}), -1, 0);
        release_port(1);
      end
      begin
        for (int c = 0; c < 4; c++) begin
          check("bp m_valid", 64'(m_valid), 64'd1);
          check("bp m_crc", 64'(m_crc), 64'(crc32_ref('{8'hA5})));
          check("bp m_port", 64'(m_port), 64'd0);
          check("bp s_ready", 64'(s_ready), 64'd0);
          @(negedge clk);
        end
        @(posedge clk);
        #1 m_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("no grant at handshake+1", 64'(s_ready), 64'd0);
        @(negedge clk);
        check("grant after handshake", 64'(s_ready), 64'b0010);
      end
    join
    drain();

    // Source stall mid-frame with port 1 requesting
    fork
      begin
        drive_frame(0, f9, 1'b1, 32'hCBF43926, 3, 3);
        release_port(0);
      end
      begin
        repeat (3) @(negedge clk);
        drive_frame(1, '{8'h77}, 1'b1, crc32_ref('{8'h77}), -1, 0);
        release_port(1);
      end
    join
    drain();

    // Asynchronous reset mid-frame, then a full resend
    drive_frame(0, f1234, 1'b0, 32'h0, -1, 0);
    #3 rst_n = 1'b0;
    #1;
    check("async reset m_valid", 64'(m_valid), 64'd0);
    check("async reset s_ready", 64'(s_ready), 64'd0);
    check("async reset m_crc", 64'(m_crc), 64'd0);
    s_valid = '0;
    s_last  = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive_frame(0, f9, 1'b1, 32'hCBF43926, -1, 0);
    release_port(0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/lfsr_crc_arbiter.md
# lfsr_crc_arbiter

Shares one parallel LFSR CRC datapath (`lfsr` instance, feed-forward off) among `PORTS` stream requesters, one whole frame at a time. A round-robin arbiter grants one port per frame. The block seeds the CRC state, steps it once per accepted beat, and presents the final CRC with the source port number on a valid/ready result interface. It sits between packet sources (MAC TX lanes, DMA channels) and FCS insertion/checking logic that would otherwise need one `lfsr_crc` per channel.

## Interface
- `PORTS`, 4: number of requesters, 2..16.
- `DATA_WIDTH`, 8: beat width; one LFSR shift per bit.
- `LFSR_WIDTH`, 32: CRC width.
- `LFSR_POLY`, 32'h04c11db7: polynomial, top term implied.
- `LFSR_INIT`, all ones: seed loaded at frame start.
- `LFSR_CONFIG`, "GALOIS": passed to `lfsr`.
- `REVERSE`, 1: bit-reverse input/output (LSB first).
- `INVERT`, 1: invert the final CRC.
- `STYLE`, "AUTO": passed to `lfsr`.
- Ports:
  - `clk`  in  1  sole clock; all logic on the rising edge.
  - `rst_n`  in  1  asynchronous, active-low reset.
  - `s_data`  in  PORTS*DATA_WIDTH  per-port beat; port i at bits [i*DATA_WIDTH +: DATA_WIDTH].
  - `s_valid`  in  PORTS  per-port beat valid.
  - `s_last`  in  PORTS  per-port last beat of frame.
  - `s_ready`  out  PORTS  per-port accept; at most one bit set.
  - `m_crc`  out  LFSR_WIDTH  final CRC of the completed frame.
  - `m_port`  out  $clog2(PORTS)  port that produced `m_crc`.
  - `m_valid`  out  1  result valid.
  - `m_ready`  in  1  result accept.

## Operation
- State machine: IDLE, BUSY, DONE.
- IDLE:
  - If any `s_valid` is set, grant the first set port searching upward from (`last_grant`+1) mod PORTS, wrapping.
  - Register `grant`, set `last_grant` = grant, load `state_reg` = LFSR_INIT, go to BUSY.
  - No data is consumed in this cycle.
- BUSY:
  - `s_ready[grant]` = 1; all other bits are 0.
  - On each beat with `s_valid[grant]` set: `state_reg` <= lfsr next state of (`state_reg`, `s_data[grant]`).
  - If that beat also has `s_last` set: load `m_crc` = next state, inverted if INVERT; set `m_port` = grant, `m_valid` = 1; go to DONE.
  - If `s_valid[grant]` drops mid-frame, the block waits with no timeout. Other ports stay blocked.
- DONE:
  - `s_ready` = 0 for all ports.
  - Hold `m_crc`, `m_port` and `m_valid` stable until `m_valid && m_ready`.
  - On that handshake, clear `m_valid` and go to IDLE.
- Every frame is at least one beat; a single beat with `s_last` set is a complete frame.
- `s_last` on non-granted ports is ignored.
- `s_ready` decodes registered state only; there is no combinational path from any input to `s_ready`.
- `m_crc` and `m_port` are registered.
- Reset (asynchronous, any state, including mid-frame):
  - Go to IDLE; `s_ready` = 0, `m_valid` = 0, `m_crc` = 0, `m_port` = 0.
  - `state_reg` = LFSR_INIT; `last_grant` = PORTS-1, so port 0 has first priority.
  - A partial frame is discarded. The source must restart the frame after reset.

## Timing
- Grant latency: `s_valid` sampled high in IDLE at edge T → `s_ready[grant]` high after edge T, so the first beat is accepted at edge T+1.
- Result latency: last beat accepted at edge N → `m_valid` high after edge N, carrying that frame's CRC.
- Full throughput: one beat per cycle while `s_valid[grant]` is held.
- Frame occupancy: B beats take 1 arbitration cycle + B beat cycles + at least 1 DONE cycle.
  - With `m_ready` held at 1, back-to-back frames from any ports take B+2 cycles each.
- Fairness: while ports are requesting, no port receives a second grant before every other requesting port has received one.

## Test plan
- Check value:
  - Stimulus: defaults; port 0 sends ASCII "123456789" (0x31..0x39), `s_last` on 0x39; `m_ready`=1.
  - Response: `m_crc` = 32'hCBF43926, `m_port` = 0, `m_valid` for exactly one cycle.
- Single-beat frame:
  - Stimulus: port 2 sends one beat 0x00 with `s_last`.
  - Response: `m_crc` = 32'hD202EF8D, `m_port` = 2.
- Round robin:
  - Stimulus: after reset, all four ports hold `s_valid` continuously with 2-beat frames.
  - Response: `m_port` sequence 0,1,2,3,0,1.
  - Stimulus: only ports 1 and 3 request.
  - Response: order 1,3,1.
  - Check in all cases: never two `s_ready` bits set at once.
- Result backpressure:
  - Stimulus: hold `m_ready`=0 for 5 cycles after `m_valid` rises, while port 1 requests.
  - Response: `m_crc`/`m_port` stable; all `s_ready`=0; no new grant until one cycle after the handshake.
- Source stall:
  - Stimulus: port 0 sends "1234", drops `s_valid` for 3 cycles, then sends "56789".
  - Response: `m_crc` = 32'hCBF43926; port 1 gets no `s_ready` during the gap.
- Reset mid-frame:
  - Stimulus: assert `rst_n`=0 asynchronously after port 0 has sent 4 bytes.
  - Response: `m_valid`, `s_ready` and `m_crc` go to 0 immediately.
  - Stimulus: resend the full "123456789".
  - Response: 32'hCBF43926.
